// File: rtl/seg_count_display_pkg.sv
// Shared constants, segment decoder and FSM state type for the seven-segment count display.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_COMMIT
  } conv_state_t;

  // gfedcba, active-low
  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Minimum 1 so that single-entry ranges still get a real bit.
  function automatic int unsigned log2ceil(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/seg_count_display_if.sv
// Host-side bundle of the count display: field values, load handshake and display options.
interface seg_count_display_if #(
  parameter int unsigned FIELDS = 2,
  parameter int unsigned VAL_W  = 7
);
  logic [FIELDS*VAL_W-1:0] values;
  logic                    load;
  logic [FIELDS-1:0]       blink_mask;
  logic                    lz_en;
  logic                    busy;
  logic [FIELDS-1:0]       ovf;

  modport master (output values, load, blink_mask, lz_en, input busy, ovf);
  modport slave  (input values, load, blink_mask, lz_en, output busy, ovf);
endinterface

// File: rtl/seg_count_display_bin2bcd_seq.sv
// Sequential double-dabble converter: one VAL_W value into DPF+1 BCD nibbles, one bit per cycle.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned VAL_W = 7,
  parameter int unsigned DPF   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [VAL_W-1:0]       din,
  output logic                   busy,
  output logic                   done,
  output logic [4*(DPF+1)-1:0]   bcd,
  output logic                   carry
);
  localparam int unsigned BW = 4*(DPF+1);
  localparam int unsigned CW = log2ceil(VAL_W);

  logic [VAL_W-1:0] sh;
  logic [CW-1:0]    cnt;
  logic [BW:0]      step_start;
  logic [BW:0]      step_run;

  // Result MSB is the bit pushed out of the top nibble; a set bit means the value outgrew the register.
  function automatic logic [BW:0] dabble(input logic [BW-1:0] b, input logic bit_in);
    logic [BW-1:0] a;
    a = b;
    for (int unsigned i = 0; i < DPF + 1; i++)
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    return {a, bit_in};
  endfunction

  // The start cycle already performs the first shift so a field takes exactly VAL_W cycles.
  always_comb begin
    step_start = dabble('0, din[VAL_W-1]);
    step_run   = dabble(bcd, sh[VAL_W-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bcd   <= '0;
      sh    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      carry <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd   <= step_start[BW-1:0];
        carry <= step_start[BW];
        sh    <= din << 1;
        cnt   <= CW'(VAL_W - 1);
        busy  <= (VAL_W > 1);
        done  <= (VAL_W == 1);
      end else if (busy) begin
        bcd   <= step_run[BW-1:0];
        carry <= carry | step_run[BW];
        sh    <= sh << 1;
        cnt   <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seg_count_display.sv
// Multiplexed seven-segment display of FIELDS binary counters with blanking, blink and overflow dash.
module seg_count_display
  import seg_pkg::*;
#(
  parameter int unsigned FIELDS  = 2,
  parameter int unsigned DPF     = 2,
  parameter int unsigned VAL_W   = 7,
  parameter int unsigned SCAN_W  = 17,
  parameter int unsigned BLINK_W = 25
) (
  input  logic                   clk,
  input  logic                   rst,
  seg_count_display_if.slave     host,
  output logic [6:0]             display,
  output logic [FIELDS*DPF-1:0]  digit
);
  localparam int unsigned ND = FIELDS*DPF;
  localparam int unsigned IW = log2ceil(ND);
  localparam int unsigned BW = 4*(DPF+1);
  localparam int unsigned FW = log2ceil(FIELDS);
  localparam int unsigned CW = log2ceil(VAL_W);
  localparam logic [SCAN_W-1:0] SCAN_LAST =
    SCAN_W'(((ND - 1) << (SCAN_W - IW)) | ((1 << (SCAN_W - IW)) - 1));

  conv_state_t state, state_nxt;

  logic [FIELDS*VAL_W-1:0] lat;
  logic                    pending;
  logic [FW-1:0]           fidx;
  logic [CW-1:0]           bcnt;
  logic                    last_bit, last_field;
  logic                    latch, commit;
  logic [BW:0]             shadow   [FIELDS];
  logic [4*DPF-1:0]        disp_bcd [FIELDS];
  logic [FIELDS-1:0]       ovf_q;

  logic                    cv_start, cv_busy, cv_done, cv_carry;
  logic [VAL_W-1:0]        cv_din;
  logic [BW-1:0]           cv_bcd;
  logic [BW:0]             cv_res;

  logic [SCAN_W-1:0]       scan_cnt;
  logic [BLINK_W-1:0]      blink_cnt;
  logic [IW-1:0]           idx;
  logic [6:0]              seg_nxt;

  function automatic logic field_ovf(input logic [BW:0] r);
    return r[BW] | (r[BW-1 -: 4] != 4'd0);
  endfunction

  assign last_bit   = (bcnt == CW'(VAL_W - 1));
  assign last_field = (fidx == FW'(FIELDS - 1));
  assign cv_din     = lat[fidx*VAL_W +: VAL_W];
  assign cv_res     = {cv_carry, cv_bcd};
  assign host.busy  = (state != ST_IDLE);
  assign host.ovf   = ovf_q;

  bin2bcd_seq #(.VAL_W(VAL_W), .DPF(DPF)) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (cv_start),
    .din   (cv_din),
    .busy  (cv_busy),
    .done  (cv_done),
    .bcd   (cv_bcd),
    .carry (cv_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cv_start  = 1'b0;
    latch     = 1'b0;
    commit    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (host.load) begin
          latch     = 1'b1;
          state_nxt = ST_CONV;
        end
      end
      ST_CONV: begin
        cv_start = (bcnt == '0) && !cv_busy;
        if (last_bit && last_field) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit = 1'b1;
        // A load arriving during the commit cycle is treated like an earlier pending one.
        if (pending || host.load) begin
          latch     = 1'b1;
          state_nxt = ST_CONV;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Each field's result surfaces (done) during the next field's start cycle; the last one during COMMIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lat     <= '0;
      pending <= 1'b0;
      fidx    <= '0;
      bcnt    <= '0;
      ovf_q   <= '0;
      for (int unsigned f = 0; f < FIELDS; f++) begin
        shadow[f]   <= '0;
        disp_bcd[f] <= '0;
      end
    end else begin
      if (latch) begin
        lat  <= host.values;
        fidx <= '0;
        bcnt <= '0;
      end else if (state == ST_CONV) begin
        if (last_bit) begin
          bcnt <= '0;
          fidx <= fidx + 1'b1;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end

      if (latch)                               pending <= 1'b0;
      else if (host.load && state != ST_IDLE)  pending <= 1'b1;

      if (cv_done && state == ST_CONV) shadow[fidx - 1'b1] <= cv_res;

      if (commit) begin
        for (int unsigned f = 0; f + 1 < FIELDS; f++) begin
          disp_bcd[f] <= shadow[f][4*DPF-1:0];
          ovf_q[f]    <= field_ovf(shadow[f]);
        end
        disp_bcd[FIELDS-1] <= cv_res[4*DPF-1:0];
        ovf_q[FIELDS-1]    <= field_ovf(cv_res);
      end
    end
  end

  assign idx = scan_cnt[SCAN_W-1 -: IW];

  always_comb begin
    seg_nxt = SEG_BLANK;
    for (int unsigned f = 0; f < FIELDS; f++)
      for (int unsigned d = 0; d < DPF; d++)
        if (idx == IW'(f*DPF + d)) begin
          if (ovf_q[f])
            seg_nxt = SEG_DASH;
          else if (host.blink_mask[f] && !blink_cnt[BLINK_W-1])
            seg_nxt = SEG_BLANK;
          else if (host.lz_en && d != 0 && (disp_bcd[f] >> (4*d)) == '0)
            seg_nxt = SEG_BLANK;
          else
            seg_nxt = seg_decode(disp_bcd[f][4*d +: 4]);
        end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt  <= '0;
      blink_cnt <= '0;
      display   <= SEG_BLANK;
      digit     <= '1;
    end else begin
      scan_cnt  <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
      blink_cnt <= blink_cnt + 1'b1;
      display   <= seg_nxt;
      digit     <= ~(ND'(1) << idx);
    end
  end

endmodule

// File: tb/tb_seg_count_display.sv
// Bench for seg_count_display: directed scenarios plus random traffic against an arithmetic reference.
module tb_seg_count_display;
  localparam int unsigned FIELDS   = 2;
  localparam int unsigned DPF      = 2;
  localparam int unsigned VAL_W    = 7;
  localparam int unsigned SCAN_W   = 2;
  localparam int unsigned BLINK_W  = 4;
  localparam int unsigned ND       = FIELDS*DPF;
  localparam int          CONV_CYC = FIELDS*VAL_W + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [6:0]    display;
  logic [ND-1:0] digit;

  seg_count_display_if #(.FIELDS(FIELDS), .VAL_W(VAL_W)) host ();

  seg_count_display #(
    .FIELDS(FIELDS), .DPF(DPF), .VAL_W(VAL_W), .SCAN_W(SCAN_W), .BLINK_W(BLINK_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .host    (host),
    .display (display),
    .digit   (digit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: committed integers per field, digits by /10 and %10, timing by a countdown.
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int         m_cv  [FIELDS];
  int         m_lat [FIELDS];
  bit         m_busy, m_pend;
  int         m_rem, m_scan, m_blink;
  logic [6:0] m_disp;
  logic [ND-1:0] m_dig;
  int         mf, md, mv, mp;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FIELDS; i++) m_cv[i] = 0;
      m_busy = 0; m_pend = 0; m_rem = 0; m_scan = 0; m_blink = 0;
      m_disp = 7'h7F; m_dig = '1;
    end else begin
      mf = m_scan / DPF;
      md = m_scan % DPF;
      mv = m_cv[mf];
      mp = 1;
      for (int j = 0; j < md; j++) mp = mp * 10;
      if (mv >= 100)                                m_disp = 7'h3F;
      else if (host.blink_mask[mf] && m_blink < 8)  m_disp = 7'h7F;
      else if (host.lz_en && md > 0 && mv < mp)     m_disp = 7'h7F;
      else                                          m_disp = seg_tab[(mv / mp) % 10];
      m_dig   = ~(ND'(1) << m_scan);
      m_scan  = (m_scan + 1) % ND;
      m_blink = (m_blink + 1) % 16;
      if (m_busy) begin
        if (m_rem == 1) begin
          for (int i = 0; i < FIELDS; i++) m_cv[i] = m_lat[i];
          if (m_pend || host.load) begin
            for (int i = 0; i < FIELDS; i++) m_lat[i] = int'(host.values[i*VAL_W +: VAL_W]);
            m_pend = 0;
            m_rem  = CONV_CYC;
          end else begin
            m_busy = 0;
          end
        end else begin
          m_rem = m_rem - 1;
          if (host.load) m_pend = 1;
        end
      end else if (host.load) begin
        for (int i = 0; i < FIELDS; i++) m_lat[i] = int'(host.values[i*VAL_W +: VAL_W]);
        m_busy = 1;
        m_rem  = CONV_CYC;
      end
    end
  end

  task automatic tick();
    logic [FIELDS-1:0] eo;
    @(negedge clk);
    for (int i = 0; i < FIELDS; i++) eo[i] = (m_cv[i] >= 100);
    check("display", 32'(display), 32'(m_disp));
    check("digit",   32'(digit),   32'(m_dig));
    check("busy",    32'(host.busy), 32'(m_busy));
    check("ovf",     32'(host.ovf),  32'(eo));
  endtask

  logic [6:0] seen [ND];

  task automatic capture();
    for (int k = 0; k < ND; k++) seen[k] = 'x;
    for (int k = 0; k < ND; k++) begin
      tick();
      for (int i = 0; i < ND; i++)
        if (digit == ~(ND'(1) << i)) seen[i] = display;
    end
  endtask

  task automatic run_until_idle(input int max, output int n);
    n = 0;
    while (host.busy && n < max) begin
      n++;
      tick();
    end
  endtask

  task automatic load_once(input logic [FIELDS*VAL_W-1:0] v);
    host.values = v;
    host.load   = 1'b1;
    tick();
    host.load   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt0, cnt2, nbusy;
    host.values = '0; host.load = 1'b0; host.blink_mask = '0; host.lz_en = 1'b0;

    // Reset state
    rst = 1'b0;
    tick();
    check("rst_digit",   32'(digit), 32'hF);
    check("rst_display", 32'(display), 32'h7F);
    check("rst_busy",    32'(host.busy), 32'h0);
    check("rst_ovf",     32'(host.ovf), 32'h0);
    tick();
    rst = 1'b1;

    // {42, 7} with leading-zero blanking
    host.lz_en = 1'b1;
    load_once({7'd42, 7'd7});
    run_until_idle(100, n);
    check("busy_len_single", 32'(n), 32'd15);
    capture();
    check("d0_7",     32'(seen[0]), 32'h78);
    check("d1_blank", 32'(seen[1]), 32'h7F);
    check("d2_2",     32'(seen[2]), 32'h24);
    check("d3_4",     32'(seen[3]), 32'h19);

    // Overflow dash, then zero with blanking
    load_once({7'd42, 7'd100});
    run_until_idle(100, n);
    check("ovf_100", 32'(host.ovf), 32'h1);
    capture();
    check("d0_dash", 32'(seen[0]), 32'h3F);
    check("d1_dash", 32'(seen[1]), 32'h3F);
    load_once({7'd42, 7'd0});
    run_until_idle(100, n);
    capture();
    check("d0_zero",  32'(seen[0]), 32'h40);
    check("d1_lz",    32'(seen[1]), 32'h7F);

    // Loads while busy collapse into one follow-up conversion
    load_once({7'd42, 7'd42});
    host.values = {7'd5, 7'd9};
    n = 1;
    for (int k = 1; k < 100; k++) begin
      host.load = (k == 4 || k == 8);
      tick();
      if (!host.busy) break;
      n++;
    end
    host.load = 1'b0;
    check("busy_len_pending", 32'(n), 32'd30);
    capture();
    check("d0_9", 32'(seen[0]), 32'h10);
    check("d1_b", 32'(seen[1]), 32'h7F);
    check("d2_5", 32'(seen[2]), 32'h12);
    check("d3_b", 32'(seen[3]), 32'h7F);

    // Blink on field 1 only
    host.blink_mask = 2'b10;
    cnt0 = 0; cnt2 = 0;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (digit == 4'b1110 && display == 7'h7F) cnt0++;
      if (digit == 4'b1011 && display == 7'h7F) cnt2++;
    end
    check("blink_d0_never", 32'(cnt0), 32'd0);
    check("blink_d2_half",  32'(cnt2), 32'd4);
    host.blink_mask = 2'b00;

    // Reset in the middle of a conversion
    load_once({7'd99, 7'd99});
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort_busy", 32'(host.busy), 32'h0);
    check("abort_ovf",  32'(host.ovf), 32'h0);
    capture();
    check("abort_d0", 32'(seen[0]), 32'h40);
    check("abort_d1", 32'(seen[1]), 32'h7F);
    check("abort_d2", 32'(seen[2]), 32'h40);
    check("abort_d3", 32'(seen[3]), 32'h7F);
    nbusy = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (host.busy) nbusy++;
    end
    check("abort_no_commit", 32'(nbusy), 32'd0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      host.values = (FIELDS*VAL_W)'($urandom);
      host.load   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) host.blink_mask = FIELDS'($urandom);
      if ($urandom_range(0, 29) == 0) host.lz_en = ~host.lz_en;
      rst = ($urandom_range(0, 249) != 0);
      tick();
    end
    rst = 1'b1;
    host.load = 1'b0;
    for (int k = 0; k < 40; k++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
